// File: rtl/div_bcd_formatter_pkg.sv
// Shared types and constants for the divider BCD formatter.
package div_fmt_pkg;

    localparam int unsigned W_DEF          = 8;
    localparam int unsigned ND_DEF         = 3;
    localparam int unsigned BCD_ADJ_THRESH = 5;
    localparam int unsigned BCD_ADJ_ADD    = 3;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

endpackage

// File: rtl/div_bcd_formatter_if.sv
// Operand/result handshake bundle between the divider, this formatter and the display driver.
interface div_bcd_formatter_if
    import div_fmt_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned ND = ND_DEF
);

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    quo;
    logic [W-1:0]    rem;
    logic            dbz;
    logic            out_valid;
    logic            out_ready;
    logic [4*ND-1:0] q_bcd;
    logic [4*ND-1:0] r_bcd;
    logic            err;

    modport master (
        output in_valid, quo, rem, dbz, out_ready,
        input  in_ready, out_valid, q_bcd, r_bcd, err
    );

    modport slave (
        input  in_valid, quo, rem, dbz, out_ready,
        output in_ready, out_valid, q_bcd, r_bcd, err
    );

endinterface

// File: rtl/div_bcd_formatter_bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift {bcd,bin} left by one.
module bcd_dabble_step
    import div_fmt_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned ND = ND_DEF
) (
    input  logic [4*ND-1:0] i_bcd,
    input  logic [W-1:0]    i_bin,
    output logic [4*ND-1:0] o_bcd,
    output logic [W-1:0]    o_bin
);

    logic [4*ND-1:0] w_adj;

    // Per-digit adjust followed by the combined left shift.
    always_comb begin
        w_adj = i_bcd;
        for (int unsigned d = 0; d < ND; d++) begin
            if (i_bcd[4*d +: 4] >= 4'(BCD_ADJ_THRESH)) begin
                w_adj[4*d +: 4] = i_bcd[4*d +: 4] + 4'(BCD_ADJ_ADD);
            end
        end
        {o_bcd, o_bin} = {w_adj, i_bin} << 1;
    end

endmodule

// File: rtl/div_bcd_formatter.sv
// Captures divider quotient/remainder/dbz, converts both to BCD in W steps, presents with valid/ready.
module div_bcd_formatter
    import div_fmt_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned ND = ND_DEF
) (
    input logic                clk,
    input logic                rst,
    div_bcd_formatter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_qbin;
    logic [W-1:0]     r_rbin;
    logic [4*ND-1:0]  r_qacc;
    logic [4*ND-1:0]  r_racc;
    logic             r_dbz;
    logic [4*ND-1:0]  r_q_bcd;
    logic [4*ND-1:0]  r_r_bcd;
    logic             r_err;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_last;
    logic [W-1:0]     w_qbin_nxt;
    logic [W-1:0]     w_rbin_nxt;
    logic [4*ND-1:0]  w_qacc_nxt;
    logic [4*ND-1:0]  w_racc_nxt;

    bcd_dabble_step #(.W(W), .ND(ND)) u_step_q (
        .i_bcd (r_qacc),
        .i_bin (r_qbin),
        .o_bcd (w_qacc_nxt),
        .o_bin (w_qbin_nxt)
    );

    bcd_dabble_step #(.W(W), .ND(ND)) u_step_r (
        .i_bcd (r_racc),
        .i_bin (r_rbin),
        .o_bcd (w_racc_nxt),
        .o_bin (w_rbin_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_last      = (r_cnt == CNT_W'(W - 1));
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = CONV;
            end
            CONV: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, conversion iterations and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_qbin  <= '0;
            r_rbin  <= '0;
            r_qacc  <= '0;
            r_racc  <= '0;
            r_dbz   <= 1'b0;
            r_q_bcd <= '0;
            r_r_bcd <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_qbin <= bus.quo;
                        r_rbin <= bus.rem;
                        r_dbz  <= bus.dbz;
                        r_qacc <= '0;
                        r_racc <= '0;
                        r_cnt  <= '0;
                    end
                end
                CONV: begin
                    r_qacc <= w_qacc_nxt;
                    r_racc <= w_racc_nxt;
                    r_qbin <= w_qbin_nxt;
                    r_rbin <= w_rbin_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_q_bcd <= w_qacc_nxt;
                        r_r_bcd <= w_racc_nxt;
                        r_err   <= r_dbz;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.q_bcd     = r_q_bcd;
    assign bus.r_bcd     = r_r_bcd;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_div_bcd_formatter.sv
// Directed and random checks of div_bcd_formatter against a decimal-arithmetic reference.
module tb_div_bcd_formatter;

    localparam int unsigned W  = 8;
    localparam int unsigned ND = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    div_bcd_formatter_if #(.W(W), .ND(ND)) bus ();

    div_bcd_formatter #(.W(W), .ND(ND)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: packed BCD from plain decimal digit extraction.
    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] res;
        int          x;
        res = '0;
        x   = v;
        for (int d = 0; d < ND; d++) begin
            res[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for out_valid (bounded), then check latency from the accept edge and the result.
    task automatic wait_result(input string tag, input int q, input int r, input bit e);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(W));
        chk({tag, "_q_bcd"}, 32'(bus.q_bcd), to_bcd(q));
        chk({tag, "_r_bcd"}, 32'(bus.r_bcd), to_bcd(r));
        chk({tag, "_err"},   32'(bus.err),   32'(e));
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_ovalid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_iready_back"}, 32'(bus.in_ready),  32'd1);
    endtask

    task automatic run_txn(input string tag, input int q, input int r, input bit e);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        bus.in_valid = 1'b1;
        bus.quo      = W'(q);
        bus.rem      = W'(r);
        bus.dbz      = e;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_iready_busy"}, 32'(bus.in_ready), 32'd0);
        wait_result(tag, q, r, e);
        handshake(tag);
    endtask

    initial begin
        int q, r, n, seen;
        bit e;
        bus.in_valid  = 1'b0;
        bus.quo       = '0;
        bus.rem       = '0;
        bus.dbz       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset then idle
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
        chk("rst_q",      32'(bus.q_bcd),     32'd0);
        chk("rst_r",      32'(bus.r_bcd),     32'd0);
        chk("rst_err",    32'(bus.err),       32'd0);
        rst = 1'b0;
        tick();
        chk("rst_iready", 32'(bus.in_ready), 32'd1);

        // Nominal and extremes
        run_txn("nom", 28, 4, 1'b0);
        run_txn("max", 255, 0, 1'b0);
        run_txn("zero", 0, 199, 1'b0);

        // Divide-by-zero with backpressure and ignored input changes
        bus.in_valid = 1'b1;
        bus.quo      = 8'd255;
        bus.rem      = 8'd37;
        bus.dbz      = 1'b1;
        tick();
        bus.quo = 8'd1;
        bus.rem = 8'd2;
        bus.dbz = 1'b0;
        wait_result("dbz", 255, 37, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.quo = W'($urandom);
            bus.rem = W'($urandom);
            tick();
            chk("hold_ovalid", 32'(bus.out_valid), 32'd1);
            chk("hold_iready", 32'(bus.in_ready),  32'd0);
            chk("hold_q",      32'(bus.q_bcd),     to_bcd(255));
            chk("hold_r",      32'(bus.r_bcd),     to_bcd(37));
            chk("hold_err",    32'(bus.err),       32'd1);
        end
        bus.in_valid = 1'b0;
        handshake("dbz");

        // Reset on the 4th conversion edge discards the result
        bus.in_valid = 1'b1;
        bus.quo      = 8'd100;
        bus.rem      = 8'd50;
        bus.dbz      = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ovalid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_q",      32'(bus.q_bcd),     32'd0);
        chk("mid_rst_r",      32'(bus.r_bcd),     32'd0);
        chk("mid_rst_err",    32'(bus.err),       32'd0);
        chk("mid_rst_iready", 32'(bus.in_ready),  32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seen++;
        end
        chk("mid_rst_no_pulse", 32'(seen), 32'd0);
        run_txn("post_rst", 9, 3, 1'b0);

        // Back-to-back with in_valid held high
        bus.in_valid = 1'b1;
        bus.quo      = 8'd12;
        bus.rem      = 8'd0;
        bus.dbz      = 1'b0;
        tick();
        bus.quo = 8'd34;
        wait_result("b2b_a", 12, 0, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("b2b_iready_after_hs", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_iready_busy", 32'(bus.in_ready), 32'd0);
        wait_result("b2b_b", 34, 0, 1'b0);
        handshake("b2b_b");

        // Random operands
        for (int i = 0; i < 24; i++) begin
            q = int'($urandom_range(255, 0));
            r = int'($urandom_range(255, 0));
            e = 1'($urandom);
            run_txn("rand", q, r, e);
        end

        // out_ready while idle has no effect
        bus.out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.out_valid === 1'b1) n++;
        end
        bus.out_ready = 1'b0;
        chk("idle_oready_ovalid", 32'(n), 32'd0);
        chk("idle_oready_iready", 32'(bus.in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
